cpu_control: RTL and testbench



---
 rtl/cpu_control.sv | 162 ++++++++++++++++
 tb/tb_cpu_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_control.sv
// cpu_control: multi-cycle instruction sequencer for the 16-bit CPU.
//
// Fetches 16-bit instructions over a request/acknowledge instruction-memory
// port, decodes them and drives the register-file/ALU datapath controls.
// Owns the program counter, latches ALU status flags and resolves
// conditional branches.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   imem_req   fetch request (high in FETCH)
//   imem_addr  fetch address, equals the program counter
//   imem_ack   fetch accepted, imem_data valid in the same cycle
//   imem_data  instruction word
//   fZ/fC/fN/fV  ALU flags from the datapath for the current controls
//   wen        register write enable, one-cycle pulse in EXEC
//   selRd/selRs/selRt  register selects
//   aluOp      ALU function
//   t          immediate operand
//   selT       1 = use t as second ALU operand
//   halted     high in the HALT state
module cpu_control #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      ADD_OP   = 4'h0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic            fZ,
  input  logic            fC,
  input  logic            fN,
  input  logic            fV,
  output logic            wen,
  output logic [3:0]      selRd,
  output logic [3:0]      selRs,
  output logic [3:0]      selRt,
  output logic [3:0]      aluOp,
  output logic [15:0]     t,
  output logic            selT,
  output logic            halted
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } flags_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  flags_t          flags_q, flags_d;

  // Instruction decode of the held instruction register.
  logic [3:0]      op;
  logic            is_alu, is_addi, is_brc, is_halt;
  logic            br_taken;
  logic [PC_W-1:0] br_off;

  assign op      = ir_q[15:12];
  assign is_addi = (op == 4'hA);
  assign is_alu  = (op <= 4'h9) || is_addi;
  assign is_brc  = (op == 4'hC);
  assign is_halt = (op == 4'hF);
  // Sign-extend the 8-bit offset to the PC width; the add then wraps mod 2^PC_W.
  assign br_off  = PC_W'($signed(ir_q[7:0]));

  always_comb begin
    br_taken = 1'b0;
    unique case (ir_q[11:8])
      4'd0:    br_taken = 1'b1;
      4'd1:    br_taken = flags_q.z;
      4'd2:    br_taken = !flags_q.z;
      4'd3:    br_taken = flags_q.c;
      4'd4:    br_taken = flags_q.n;
      4'd5:    br_taken = flags_q.v;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (is_alu) flags_d = '{z: fZ, c: fC, n: fN, v: fV};
        // pc already points past the branch, so the offset is relative to it.
        if (is_brc && br_taken) pc_d = pc_q + br_off;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state and ir only, so an
  // asynchronous reset clears them without waiting for a clock edge.
  always_comb begin
    imem_req  = (state_q == ST_FETCH);
    imem_addr = pc_q;
    wen       = (state_q == ST_EXEC) && is_alu;
    halted    = (state_q == ST_HALT);
    selRd     = '0;
    selRs     = '0;
    selRt     = '0;
    aluOp     = '0;
    t         = '0;
    selT      = 1'b0;
    if (state_q == ST_DECODE || state_q == ST_EXEC) begin
      selRd = ir_q[11:8];
      selRs = ir_q[7:4];
      selRt = ir_q[3:0];
      aluOp = is_addi ? ADD_OP : op;
      t     = {12'b0, ir_q[3:0]};
      selT  = is_addi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed testbench for cpu_control: a small instruction memory with
// programmable ack latency feeds a hand-written program; every fetch address
// and EXEC-cycle control value is compared against hand-computed values.
module tb_cpu_control;

  localparam int unsigned PC_W = 8;

  logic            clk;
  logic            rst;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic            fZ, fC, fN, fV;
  logic            wen;
  logic [3:0]      selRd, selRs, selRt, aluOp;
  logic [15:0]     t;
  logic            selT;
  logic            halted;

  cpu_control #(
    .PC_W    (PC_W),
    .RESET_PC(8'h00),
    .ADD_OP  (4'h0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_req (imem_req),
    .imem_addr(imem_addr),
    .imem_ack (imem_ack),
    .imem_data(imem_data),
    .fZ       (fZ),
    .fC       (fC),
    .fN       (fN),
    .fV       (fV),
    .wen      (wen),
    .selRd    (selRd),
    .selRs    (selRs),
    .selRt    (selRt),
    .aluOp    (aluOp),
    .t        (t),
    .selT     (selT),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {imem_req, imem_addr, wen, selRd, selRs, selRt, aluOp, t, selT, halted}, 64'd0);
  endtask

  // Instruction memory: responds shortly after each rising edge so ack and
  // data are settled well before the next edge.
  logic [15:0] mem [256];
  int          ack_delay;
  int          wait_left;

  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    wait_left = 0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        if (wait_left > 0) begin
          imem_ack = 1'b0;
          wait_left--;
        end else begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
        end
      end else begin
        imem_ack  = 1'b0;
        wait_left = ack_delay;
      end
    end
  end

  // Waits for a fetch, checks its address every request cycle, then steps
  // through DECODE and returns at the negedge of the following cycle (EXEC,
  // or HALT for a halt instruction).
  task automatic fetch_to_exec(input logic [7:0] exp_addr, input string tag, output int rc);
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req"}, imem_req, 1);
    check({tag, "_wen_off"}, wen, 0);
    rc = 0;
    while (imem_req && rc < 50) begin
      check({tag, "_addr"}, imem_addr, exp_addr);
      rc++;
      @(negedge clk);
    end
    check({tag, "_dec_wen"}, wen, 0);
    @(negedge clk);
  endtask

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] instr;
    logic [3:0]  zcnv;   // flags presented during EXEC
    logic        wen;    // expected wen in EXEC
  } step_t;

  localparam int N_STEPS = 20;
  step_t prog [N_STEPS];

  initial begin
    prog[0]  = '{8'h00, 16'h1234, 4'b0000, 1'b1};
    prog[1]  = '{8'h01, 16'hA35F, 4'b1000, 1'b1};
    prog[2]  = '{8'h02, 16'hB000, 4'b0000, 1'b0};
    prog[3]  = '{8'h03, 16'hE000, 4'b0000, 1'b0};
    prog[4]  = '{8'h04, 16'h0111, 4'b1000, 1'b1};  // Z=1
    prog[5]  = '{8'h05, 16'hC1FE, 4'b0000, 1'b0};  // taken -> 4
    prog[6]  = '{8'h04, 16'h0111, 4'b0000, 1'b1};  // Z=0
    prog[7]  = '{8'h05, 16'hC1FE, 4'b0000, 1'b0};  // not taken -> 6
    prog[8]  = '{8'h06, 16'hD000, 4'b1000, 1'b0};  // NOP must not latch Z
    prog[9]  = '{8'h07, 16'hC101, 4'b0000, 1'b0};  // Z=0 -> 8
    prog[10] = '{8'h08, 16'hC0F6, 4'b0000, 1'b0};  // 9-10 -> FF
    prog[11] = '{8'hFF, 16'hC07F, 4'b0000, 1'b0};  // pc wraps to 0, +7F
    prog[12] = '{8'h7F, 16'hC605, 4'b0000, 1'b0};  // never -> 80
    prog[13] = '{8'h80, 16'hC202, 4'b0000, 1'b0};  // !Z -> 83
    prog[14] = '{8'h83, 16'hC310, 4'b0000, 1'b0};  // C=0 -> 84
    prog[15] = '{8'h84, 16'h0111, 4'b0111, 1'b1};  // C=N=V=1
    prog[16] = '{8'h85, 16'hC402, 4'b0000, 1'b0};  // N -> 88
    prog[17] = '{8'h88, 16'hC501, 4'b0000, 1'b0};  // V -> 8A
    prog[18] = '{8'h8A, 16'hC301, 4'b0000, 1'b0};  // C -> 8C
    prog[19] = '{8'h8C, 16'hF000, 4'b0000, 1'b0};  // HALT
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int bad;
    rst       = 1'b0;
    fZ        = 1'b0;
    fC        = 1'b0;
    fN        = 1'b0;
    fV        = 1'b0;
    ack_delay = 2;
    for (int a = 0; a < 256; a++) mem[a] = 16'hE000;
    #1;
    for (int i = 0; i < N_STEPS; i++) mem[prog[i].addr] = prog[i].instr;

    // Reset held low: everything quiet.
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    ack_delay = 0;  // takes effect from the second fetch

    for (int i = 0; i < N_STEPS - 1; i++) begin
      fetch_to_exec(prog[i].addr, $sformatf("s%0d", i), rc);
      check($sformatf("s%0d_req_cycles", i), rc, (i == 0) ? 3 : 1);
      check($sformatf("s%0d_wen", i), wen, prog[i].wen);
      if (i == 0) begin
        check("rtype_selRd", selRd, 2);
        check("rtype_selRs", selRs, 3);
        check("rtype_selRt", selRt, 4);
        check("rtype_aluOp", aluOp, 1);
        check("rtype_selT", selT, 0);
      end
      if (i == 1) begin
        check("addi_selT", selT, 1);
        check("addi_t", t, 16'h000F);
        check("addi_aluOp", aluOp, 4'h0);
        check("addi_selRd", selRd, 3);
        check("addi_selRs", selRs, 5);
      end
      {fZ, fC, fN, fV} = prog[i].zcnv;
    end

    // HALT: terminal, no fetches or writes.
    fetch_to_exec(prog[N_STEPS-1].addr, "halt", rc);
    check("halt_halted", halted, 1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imem_req || wen || !halted) bad++;
    end
    check("halt_quiet_cycles", bad, 0);

    // Reset out of HALT restarts fetch at RESET_PC.
    rst = 1'b0;
    #1;
    check_all_zero("halt_reset_outputs");
    @(negedge clk);
    rst = 1'b1;
    fetch_to_exec(8'h00, "restart", rc);
    check("restart_wen", wen, 1);
    {fZ, fC, fN, fV} = 4'b1000;  // latch Z=1 before the mid-EXEC reset

    // Reset asserted in the middle of an ADDI EXEC cycle.
    fetch_to_exec(8'h01, "midexec", rc);
    check("midexec_wen_before", wen, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midexec_wen_drop", wen, 0);
    check_all_zero("midexec_reset_outputs");
    mem[0] = 16'hC105;  // BRC Z,+5: must not be taken with reset flags
    {fZ, fC, fN, fV} = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    fetch_to_exec(8'h00, "post_reset_brc", rc);
    check("post_reset_brc_wen", wen, 0);
    fetch_to_exec(8'h01, "post_reset_next", rc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
